// File: rtl/linebuf_pkg.sv
// Shared FSM encodings and width helpers for the linebuf_ram line buffer.
package linebuf_pkg;

   typedef enum logic {
      F_IDLE = 1'b0,
      F_FILL = 1'b1
   } fill_state_e;

   typedef enum logic {
      C_IDLE = 1'b0,
      C_ACK  = 1'b1
   } cpu_state_e;

   function automatic int words_f(input int addr_width);
      return 1 << addr_width;
   endfunction

   function automatic int be_width_f(input int data_width);
      return data_width / 8;
   endfunction

endpackage

// File: rtl/linebuf_mem.sv
// Dual-port RAM: port A full-word write, port B byte-enabled read/write, one-cycle synchronous read.
// "ALTERA" registers the read address (block-RAM friendly); "GENERIC" registers the read data.
module linebuf_mem
   import linebuf_pkg::*;
#(
   parameter int    DATA_WIDTH = 32,
   parameter int    ADDR_WIDTH = 3,
   parameter string TECHNOLOGY = "GENERIC"
) (
   input  logic                              clk,
   input  logic                              a_we_i,
   input  logic [ADDR_WIDTH-1:0]             a_addr_i,
   input  logic [DATA_WIDTH-1:0]             a_di_i,
   input  logic                              b_en_i,
   input  logic [be_width_f(DATA_WIDTH)-1:0] b_we_i,
   input  logic [ADDR_WIDTH-1:0]             b_addr_i,
   input  logic [DATA_WIDTH-1:0]             b_di_i,
   output logic [DATA_WIDTH-1:0]             b_do_o
);

   localparam int WORDS = words_f(ADDR_WIDTH);
   localparam int BE_W  = be_width_f(DATA_WIDTH);

   logic [DATA_WIDTH-1:0] mem_q [WORDS];

   // Both ports never target the same word in one cycle: fill writes only
   // unfilled words and the CPU only touches filled ones.
   always_ff @(posedge clk) begin
      if (a_we_i) begin
         mem_q[a_addr_i] <= a_di_i;
      end
      for (int i = 0; i < BE_W; i++) begin
         if (b_we_i[i]) begin
            mem_q[b_addr_i][8*i +: 8] <= b_di_i[8*i +: 8];
         end
      end
   end

   generate
      if (TECHNOLOGY == "ALTERA") begin : g_altera
         logic [ADDR_WIDTH-1:0] rd_addr_q;
         always_ff @(posedge clk) begin
            if (b_en_i) begin
               rd_addr_q <= b_addr_i;
            end
         end
         assign b_do_o = mem_q[rd_addr_q];
      end else begin : g_generic
         logic [DATA_WIDTH-1:0] rd_dat_q;
         always_ff @(posedge clk) begin
            if (b_en_i) begin
               rd_dat_q <= mem_q[b_addr_i];
            end
         end
         assign b_do_o = rd_dat_q;
      end
   endgenerate

endmodule

// File: rtl/linebuf_ram.sv
// Critical-word-first line fill with hit-under-fill CPU port; a hit acks the cycle after accept.
// CPU stalls on unfilled words during a fill; define LINEBUF_FORWARD_EN to bypass in_data to a waiting read.
module linebuf_ram
   import linebuf_pkg::*;
#(
   parameter int    DATA_WIDTH = 32,
   parameter int    ADDR_WIDTH = 3,
   parameter string TECHNOLOGY = "GENERIC"
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              fill_start,
   input  logic [ADDR_WIDTH-1:0]             fill_addr,
   output logic                              fill_busy,
   output logic                              fill_done,
   input  logic                              in_valid,
   input  logic [DATA_WIDTH-1:0]             in_data,
   output logic                              in_ready,
   input  logic                              cpu_req,
   input  logic [ADDR_WIDTH-1:0]             cpu_addr,
   input  logic [be_width_f(DATA_WIDTH)-1:0] cpu_we,
   input  logic [DATA_WIDTH-1:0]             cpu_di,
   output logic [DATA_WIDTH-1:0]             cpu_do,
   output logic                              cpu_ack,
   output logic                              cpu_err,
   output logic [words_f(ADDR_WIDTH)-1:0]    valid,
   output logic [words_f(ADDR_WIDTH)-1:0]    dirty
);

   localparam int WORDS = words_f(ADDR_WIDTH);
   localparam int BE_W  = be_width_f(DATA_WIDTH);

   fill_state_e           fill_q, fill_d;
   logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
   logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
   logic                  done_q, done_d;
   logic [WORDS-1:0]      valid_q, valid_d;
   logic [WORDS-1:0]      dirty_q, dirty_d;

   cpu_state_e            cpu_q, cpu_d;
   logic                  err_q, err_d;
   logic                  fwd_q, fwd_d;
   logic [DATA_WIDTH-1:0] fwd_dat_q, fwd_dat_d;

   logic                  beat_acc;
   logic                  fill_clr;
   logic                  cpu_wr;
   logic                  fwd_hit;
   logic                  b_en;
   logic [BE_W-1:0]       b_we;
   logic [WORDS-1:0]      dirty_set;
   logic [DATA_WIDTH-1:0] b_do;

   assign fill_busy = (fill_q == F_FILL);
   assign in_ready  = fill_busy;
   assign beat_acc  = fill_busy && in_valid;
   assign fill_clr  = (fill_q == F_IDLE) && fill_start;
   assign cpu_wr    = |cpu_we;

`ifdef LINEBUF_FORWARD_EN
   assign fwd_hit = cpu_req && !cpu_wr && !valid_q[cpu_addr] && beat_acc && (ptr_q == cpu_addr);
`else
   assign fwd_hit = 1'b0;
`endif

   // Fill engine: the pointer wraps naturally; cnt all-ones marks the final beat.
   always_comb begin
      fill_d  = fill_q;
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      done_d  = 1'b0;
      valid_d = valid_q;
      case (fill_q)
         F_IDLE: begin
            if (fill_start) begin
               valid_d = '0;
               ptr_d   = fill_addr;
               cnt_d   = '0;
               fill_d  = F_FILL;
            end
         end
         F_FILL: begin
            if (in_valid) begin
               valid_d = valid_q | (WORDS'(1) << ptr_q);
               ptr_d   = ptr_q + 1'b1;
               cnt_d   = cnt_q + 1'b1;
               if (&cnt_q) begin
                  fill_d = F_IDLE;
                  done_d = 1'b1;
               end
            end
         end
      endcase
   end

   always_comb begin
      cpu_d     = cpu_q;
      err_d     = 1'b0;
      fwd_d     = 1'b0;
      fwd_dat_d = fwd_dat_q;
      b_en      = 1'b0;
      b_we      = '0;
      dirty_set = '0;
      case (cpu_q)
         C_IDLE: begin
            if (cpu_req) begin
               if (valid_q[cpu_addr]) begin
                  cpu_d = C_ACK;
                  b_en  = 1'b1;
                  if (cpu_wr) begin
                     b_we      = cpu_we;
                     dirty_set = WORDS'(1) << cpu_addr;
                  end
               end else if (fwd_hit) begin
                  cpu_d     = C_ACK;
                  fwd_d     = 1'b1;
                  fwd_dat_d = in_data;
               end else if (!fill_busy) begin
                  // Nothing will ever fill this word: fail it without touching the RAM.
                  cpu_d = C_ACK;
                  err_d = 1'b1;
               end
            end
         end
         C_ACK: begin
            cpu_d = C_IDLE;
         end
      endcase
   end

   assign dirty_d = fill_clr ? '0 : (dirty_q | dirty_set);

   always_ff @(posedge clk) begin
      if (rst) begin
         fill_q    <= F_IDLE;
         ptr_q     <= '0;
         cnt_q     <= '0;
         done_q    <= 1'b0;
         valid_q   <= '0;
         dirty_q   <= '0;
         cpu_q     <= C_IDLE;
         err_q     <= 1'b0;
         fwd_q     <= 1'b0;
         fwd_dat_q <= '0;
      end else begin
         fill_q    <= fill_d;
         ptr_q     <= ptr_d;
         cnt_q     <= cnt_d;
         done_q    <= done_d;
         valid_q   <= valid_d;
         dirty_q   <= dirty_d;
         cpu_q     <= cpu_d;
         err_q     <= err_d;
         fwd_q     <= fwd_d;
         fwd_dat_q <= fwd_dat_d;
      end
   end

   linebuf_mem #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH),
      .TECHNOLOGY (TECHNOLOGY)
   ) u_mem (
      .clk      (clk),
      .a_we_i   (beat_acc),
      .a_addr_i (ptr_q),
      .a_di_i   (in_data),
      .b_en_i   (b_en),
      .b_we_i   (b_we),
      .b_addr_i (cpu_addr),
      .b_di_i   (cpu_di),
      .b_do_o   (b_do)
   );

   assign fill_done = done_q;
   assign valid     = valid_q;
   assign dirty     = dirty_q;
   assign cpu_ack   = (cpu_q == C_ACK);
   assign cpu_err   = cpu_ack && err_q;
   assign cpu_do    = (cpu_ack && !err_q) ? (fwd_q ? fwd_dat_q : b_do) : '0;

endmodule

// File: tb/tb_linebuf_ram.sv
// Directed bench for linebuf_ram (DATA_WIDTH=32, ADDR_WIDTH=3).
module tb_linebuf_ram;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        fill_start = 1'b0;
   logic [2:0]  fill_addr = '0;
   logic        fill_busy;
   logic        fill_done;
   logic        in_valid = 1'b0;
   logic [31:0] in_data = '0;
   logic        in_ready;
   logic        cpu_req = 1'b0;
   logic [2:0]  cpu_addr = '0;
   logic [3:0]  cpu_we = '0;
   logic [31:0] cpu_di = '0;
   logic [31:0] cpu_do;
   logic        cpu_ack;
   logic        cpu_err;
   logic [7:0]  valid;
   logic [7:0]  dirty;

`ifdef LINEBUF_FORWARD_EN
   localparam int CW_ACK = 7;
`else
   localparam int CW_ACK = 8;
`endif

   int checks = 0;
   int errors = 0;

   linebuf_ram #(
      .DATA_WIDTH (32),
      .ADDR_WIDTH (3),
      .TECHNOLOGY ("GENERIC")
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .fill_start (fill_start),
      .fill_addr  (fill_addr),
      .fill_busy  (fill_busy),
      .fill_done  (fill_done),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .in_ready   (in_ready),
      .cpu_req    (cpu_req),
      .cpu_addr   (cpu_addr),
      .cpu_we     (cpu_we),
      .cpu_di     (cpu_di),
      .cpu_do     (cpu_do),
      .cpu_ack    (cpu_ack),
      .cpu_err    (cpu_err),
      .valid      (valid),
      .dirty      (dirty)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // One CPU access; lat counts edges from request to the observed ack.
   task automatic access(input logic [2:0] a, input logic [3:0] we, input logic [31:0] di,
                         output logic [31:0] dat, output logic err, output int lat);
      cpu_req  = 1'b1;
      cpu_addr = a;
      cpu_we   = we;
      cpu_di   = di;
      dat      = 'x;
      err      = 1'bx;
      lat      = 0;
      for (int i = 0; i < 20; i++) begin
         tick;
         lat++;
         if (cpu_ack) begin
            dat = cpu_do;
            err = cpu_err;
            break;
         end
      end
      cpu_req = 1'b0;
      cpu_we  = '0;
      tick;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic [31:0] dat;
      logic        err;
      int          lat;
      int          ack_cyc;
      int          done_cnt;
      int          done_cyc;
      logic [31:0] ack_dat;
      logic        ack_err;

      // Reset state
      tick;
      tick;
      chk("rst_fill_busy", 32'(fill_busy), 32'd0);
      chk("rst_fill_done", 32'(fill_done), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      chk("rst_cpu_ack", 32'(cpu_ack), 32'd0);
      chk("rst_cpu_err", 32'(cpu_err), 32'd0);
      chk("rst_cpu_do", cpu_do, 32'd0);
      chk("rst_valid", 32'(valid), 32'd0);
      chk("rst_dirty", 32'(dirty), 32'd0);
      rst = 1'b0;
      tick;

      // Read with no line loaded: error ack one cycle later
      access(3'd1, 4'b0000, 32'h0, dat, err, lat);
      chk("nofill_err", 32'(err), 32'd1);
      chk("nofill_do", dat, 32'd0);
      chk("nofill_lat", 32'(lat), 32'd1);

      // Fill from word 5 while a read of word 2 waits on the 6th beat
      fill_addr  = 3'd5;
      fill_start = 1'b1;
      tick;
      fill_start = 1'b0;
      cpu_req    = 1'b1;
      cpu_addr   = 3'd2;
      cpu_we     = 4'b0000;
      ack_cyc    = 0;
      done_cnt   = 0;
      done_cyc   = 0;
      ack_dat    = '0;
      ack_err    = 1'b0;
      for (int c = 1; c <= 12; c++) begin
         in_valid = (c <= 8);
         in_data  = 32'hA0 + 32'(c - 1);
         if (c == 1) begin
            chk("fill1_busy", 32'(fill_busy), 32'd1);
            chk("fill1_in_ready", 32'(in_ready), 32'd1);
         end
         if (cpu_ack && ack_cyc == 0) begin
            ack_cyc = c;
            ack_dat = cpu_do;
            ack_err = cpu_err;
            cpu_req = 1'b0;
         end
         if (fill_done) begin
            done_cnt++;
            done_cyc = c;
         end
         if (c == 9) chk("fill1_busy_at_done", 32'(fill_busy), 32'd0);
         tick;
      end
      in_valid = 1'b0;
      chk("cw_ack_cycle", 32'(ack_cyc), 32'(CW_ACK));
      chk("cw_ack_data", ack_dat, 32'hA5);
      chk("cw_ack_err", 32'(ack_err), 32'd0);
      chk("fill1_done_cnt", 32'(done_cnt), 32'd1);
      chk("fill1_done_cycle", 32'(done_cyc), 32'd9);
      chk("fill1_valid", 32'(valid), 32'hFF);

      for (int w = 0; w < 8; w++) begin
         access(3'(w), 4'b0000, 32'h0, dat, err, lat);
         chk($sformatf("fill1_rd_w%0d", w), dat, 32'hA0 + 32'((w + 3) % 8));
      end
      chk("hit_lat", 32'(lat), 32'd1);

      // Partial write of word 3 (fill data 0xA6)
      access(3'd3, 4'b0011, 32'h1234_5678, dat, err, lat);
      chk("wr_err", 32'(err), 32'd0);
      chk("wr_lat", 32'(lat), 32'd1);
      access(3'd3, 4'b0000, 32'h0, dat, err, lat);
      chk("wr_readback", dat, 32'h0000_5678);
      chk("wr_dirty", 32'(dirty), 32'h08);

      // Fill from word 6 with a bubble and two fill_start pulses that must be ignored
      fill_addr  = 3'd6;
      fill_start = 1'b1;
      tick;
      fill_start = 1'b0;
      chk("fill2_valid_clr", 32'(valid), 32'd0);
      chk("fill2_dirty_clr", 32'(dirty), 32'd0);
      done_cnt = 0;
      for (int c = 1; c <= 11; c++) begin
         in_valid   = (c != 3) && (c <= 9);
         in_data    = 32'hB0 + 32'((c < 3) ? c - 1 : c - 2);
         fill_start = (c == 4) || (c == 9);
         fill_addr  = 3'd1;
         if (fill_done) done_cnt++;
         if (c == 10) begin
            chk("fill2_done_at10", 32'(fill_done), 32'd1);
            chk("fill2_busy_at10", 32'(fill_busy), 32'd0);
            chk("fill2_valid", 32'(valid), 32'hFF);
         end
         tick;
      end
      fill_start = 1'b0;
      in_valid   = 1'b0;
      chk("fill2_done_cnt", 32'(done_cnt), 32'd1);
      for (int w = 0; w < 8; w++) begin
         access(3'(w), 4'b0000, 32'h0, dat, err, lat);
         chk($sformatf("fill2_rd_w%0d", w), dat, 32'hB0 + 32'((w + 2) % 8));
      end

      // Reset after the 3rd beat aborts the load
      fill_addr  = 3'd0;
      fill_start = 1'b1;
      tick;
      fill_start = 1'b0;
      for (int c = 1; c <= 3; c++) begin
         in_valid = 1'b1;
         in_data  = 32'hC0 + 32'(c - 1);
         tick;
      end
      chk("abort_valid_pre", 32'(valid), 32'h07);
      chk("abort_busy_pre", 32'(fill_busy), 32'd1);
      rst     = 1'b1;
      in_data = 32'hC3;
      tick;
      chk("abort_busy", 32'(fill_busy), 32'd0);
      chk("abort_valid", 32'(valid), 32'd0);
      chk("abort_in_ready", 32'(in_ready), 32'd0);
      rst      = 1'b0;
      in_valid = 1'b0;
      tick;
      access(3'd0, 4'b0000, 32'h0, dat, err, lat);
      chk("abort_rd_err", 32'(err), 32'd1);
      chk("abort_rd_do", dat, 32'd0);

      // Subsequent full fill from word 2
      fill_addr  = 3'd2;
      fill_start = 1'b1;
      tick;
      fill_start = 1'b0;
      for (int c = 1; c <= 9; c++) begin
         in_valid = (c <= 8);
         in_data  = 32'hD0 + 32'(c - 1);
         if (c == 9) begin
            chk("fill4_done", 32'(fill_done), 32'd1);
            chk("fill4_valid", 32'(valid), 32'hFF);
         end
         tick;
      end
      in_valid = 1'b0;
      access(3'd2, 4'b0000, 32'h0, dat, err, lat);
      chk("fill4_rd_w2", dat, 32'hD0);
      access(3'd1, 4'b0000, 32'h0, dat, err, lat);
      chk("fill4_rd_w1", dat, 32'hD7);
      chk("fill4_rd_err", 32'(err), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
